// File: rtl/cas_fsk_player_if.sv
// rtl/cas_fsk_player_if.sv - CAS buffer RAM read port between the player and the buffer
interface cas_fsk_player_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rd_addr;
  logic              rd;
  logic [7:0]        rd_data;

  modport master (output rd_addr, output rd, input rd_data);
  modport slave  (input rd_addr, input rd, output rd_data);
endinterface

// File: rtl/cas_fsk_player.sv
// rtl/cas_fsk_player.sv - CAS buffer playback engine producing the FSK tape waveform
module cas_fsk_player #(
  parameter int ADDR_W     = 16,
  parameter int HALF0      = 8889,
  parameter int HALF1      = 4444,
  parameter int PILOT_BITS = 2048,
  parameter int INVERT     = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic                play,
  input  logic                rewind,
  input  logic [ADDR_W-1:0]   len,
  cas_fsk_player_if.master    ram,
  output logic                data,
  output logic [2:0]          status
);

  localparam int HMAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int HC_W = $clog2(HMAX + 1);
  localparam int PC_W = $clog2(PILOT_BITS + 1);
  localparam logic [HC_W-1:0] H0 = HC_W'(HALF0);
  localparam logic [HC_W-1:0] H1 = HC_W'(HALF1);

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_FETCH, S_LATCH, S_BIT, S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] len_q;
  logic [8:0]        sr;
  logic [3:0]        bit_cnt;
  logic [PC_W-1:0]   pilot_cnt;
  logic [HC_W-1:0]   half_cnt;
  logic [2:0]        half_left;
  logic              level;
  logic              rd_q;
  logic              tick;

  // Bit timing only advances on ce while the motor runs in a waveform state.
  assign tick = play && ce && (state == S_PILOT || state == S_BIT);

  assign ram.rd_addr = ptr;
  assign ram.rd      = rd_q;
  assign data        = level ^ (INVERT != 0);

  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      state     <= S_IDLE;
      ptr       <= '0;
      len_q     <= '0;
      sr        <= '0;
      bit_cnt   <= '0;
      pilot_cnt <= '0;
      half_cnt  <= '0;
      half_left <= '0;
      level     <= 1'b0;
      rd_q      <= 1'b0;
      status    <= 3'd0;
    end else begin
      case (state)
        S_PILOT:                  status <= play ? 3'd1 : 3'd3;
        S_FETCH, S_LATCH, S_BIT:  status <= play ? 3'd2 : 3'd3;
        S_DONE:                   status <= 3'd4;
        default:                  status <= 3'd0;
      endcase

      case (state)
        S_IDLE: begin
          if (play) begin
            state     <= S_PILOT;
            pilot_cnt <= PC_W'(PILOT_BITS);
            half_cnt  <= H1;
            half_left <= 3'd4;
          end
        end
        S_PILOT: begin
          if (tick) begin
            if (half_cnt > HC_W'(1)) begin
              half_cnt <= half_cnt - HC_W'(1);
            end else begin
              level <= ~level;
              if (half_left > 3'd1) begin
                half_left <= half_left - 3'd1;
                half_cnt  <= H1;
              end else if (pilot_cnt > PC_W'(1)) begin
                pilot_cnt <= pilot_cnt - PC_W'(1);
                half_left <= 3'd4;
                half_cnt  <= H1;
              end else begin
                len_q <= len;
                if (len == '0) begin
                  state <= S_DONE;
                end else begin
                  state <= S_FETCH;
                  rd_q  <= 1'b1;
                end
              end
            end
          end
        end
        S_FETCH: begin
          if (play) begin
            state <= S_LATCH;
            rd_q  <= 1'b0;
          end
        end
        S_LATCH: begin
          if (play) begin
            sr        <= {1'b0, ram.rd_data};
            ptr       <= ptr + 1'b1;
            bit_cnt   <= 4'd9;
            half_cnt  <= H0;
            half_left <= 3'd2;
            state     <= S_BIT;
          end
        end
        S_BIT: begin
          if (tick) begin
            if (half_cnt > HC_W'(1)) begin
              half_cnt <= half_cnt - HC_W'(1);
            end else begin
              level <= ~level;
              if (half_left > 3'd1) begin
                half_left <= half_left - 3'd1;
                half_cnt  <= sr[8] ? H1 : H0;
              end else if (bit_cnt > 4'd1) begin
                // sr[7] becomes the next bit after the shift.
                sr        <= {sr[7:0], 1'b0};
                bit_cnt   <= bit_cnt - 4'd1;
                half_cnt  <= sr[7] ? H1 : H0;
                half_left <= sr[7] ? 3'd4 : 3'd2;
              end else if (ptr == len_q) begin
                state <= S_DONE;
              end else begin
                state <= S_FETCH;
                rd_q  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          level <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cas_fsk_player.sv
// tb/tb_cas_fsk_player.sv - directed bench for cas_fsk_player with small timing parameters
module tb_cas_fsk_player;

  logic       clk = 1'b0;
  logic       reset, ce, play, rewind;
  logic [3:0] len;
  logic       data;
  logic [2:0] status;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [16];
  logic wave[$];
  logic wl;
  int ce_div = 0;
  int ce_ph = 0;

  cas_fsk_player_if #(.ADDR_W(4)) bus ();

  cas_fsk_player #(
    .ADDR_W(4), .HALF0(4), .HALF1(2), .PILOT_BITS(2), .INVERT(0)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .play(play), .rewind(rewind),
    .len(len), .ram(bus), .data(data), .status(status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd) bus.rd_data <= mem[bus.rd_addr];

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ce_div != 0) begin
      ce = (ce_ph == 0);
      ce_ph = (ce_ph + 1) % 4;
    end
  endtask

  // One bit is 8 clks at ce=1: '1' toggles every 2 clks, '0' every 4.
  task automatic push_bit(input logic b);
    for (int j = 1; j <= 8; j++) begin
      if (b ? (j % 2 == 0) : (j % 4 == 0)) wl = ~wl;
      wave.push_back(wl);
    end
  endtask

  task automatic build_wave(input int nbytes);
    logic [7:0] v;
    wave.delete();
    wl = 1'b0;
    wave.push_back(wl);
    push_bit(1'b1);
    push_bit(1'b1);
    for (int i = 0; i < nbytes; i++) begin
      v = mem[i];
      wave.push_back(wl);
      wave.push_back(wl);
      push_bit(1'b0);
      for (int k = 7; k >= 0; k--) push_bit(v[k]);
    end
  endtask

  task automatic run_seq(input int nbytes, input int pause_at, input int rewind_at);
    int n;
    logic exp_rd;
    int exp_st;
    build_wave(nbytes);
    n = wave.size();
    for (int m = 0; m < n; m++) begin
      step();
      chk("data", data, wave[m]);
      exp_rd = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
        if (m == 16 + 74 * i) begin
          exp_rd = 1'b1;
          chk("rd_addr", bus.rd_addr, i);
        end
      end
      chk("rd", bus.rd, exp_rd);
      exp_st = (m == 0) ? 0 : (m <= 16) ? 1 : 2;
      chk("status", status, exp_st);
      if (m == pause_at) begin
        play = 1'b0;
        for (int p = 0; p < 10; p++) begin
          step();
          chk("pause_data", data, wave[m]);
          chk("pause_status", status, 3);
        end
        play = 1'b1;
      end
      if (m == rewind_at) begin
        rewind = 1'b1;
        step();
        rewind = 1'b0;
        chk("rewind_status", status, 0);
        chk("rewind_addr", bus.rd_addr, 0);
        chk("rewind_rd", bus.rd, 0);
        chk("rewind_data", data, 0);
        return;
      end
    end
    step();
    chk("done_status", status, 4);
    chk("done_data", data, 0);
    chk("done_rd", bus.rd, 0);
  endtask

  task automatic idle_reset();
    play = 1'b0;
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    step();
    chk("idle_status", status, 0);
  endtask

  initial begin
    int tg[$];
    int rd_cnt, rd_cyc;
    logic prev;

    reset = 1'b1; ce = 1'b1; play = 1'b0; rewind = 1'b0; len = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 3; i++) step();
    chk("rst_data", data, 0);
    chk("rst_status", status, 0);
    chk("rst_rd", bus.rd, 0);
    chk("rst_addr", bus.rd_addr, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_data", data, 0);
      chk("idle_status", status, 0);
      chk("idle_rd", bus.rd, 0);
    end

    // single byte 0xA5
    mem[0] = 8'hA5; len = 4'd1; play = 1'b1;
    run_seq(1, -1, -1);

    // two bytes, second fetch 74 clks after the first
    idle_reset();
    mem[0] = 8'h00; mem[1] = 8'hFF; len = 4'd2; play = 1'b1;
    run_seq(2, -1, -1);

    // pause 10 clks in the middle of the first data bit
    idle_reset();
    mem[0] = 8'hA5; len = 4'd1; play = 1'b1;
    run_seq(1, 30, -1);

    // rewind during the second byte, then full replay
    idle_reset();
    mem[0] = 8'h00; mem[1] = 8'hFF; len = 4'd2; play = 1'b1;
    run_seq(2, -1, 120);
    run_seq(2, -1, -1);

    // empty file
    idle_reset();
    len = 4'd0; play = 1'b1;
    run_seq(0, -1, -1);

    // ce at one tick in four
    idle_reset();
    mem[0] = 8'hA5; len = 4'd1;
    ce_div = 1; ce_ph = 0;
    play = 1'b1;
    prev = data;
    rd_cnt = 0; rd_cyc = -1;
    for (int c = 0; c < 600; c++) begin
      step();
      if (data !== prev) tg.push_back(c);
      prev = data;
      if (bus.rd === 1'b1) begin
        rd_cnt++;
        rd_cyc = c;
      end
    end
    chk("ce4_toggles", tg.size(), 34);
    chk("ce4_rd_count", rd_cnt, 1);
    chk("ce4_status", status, 4);
    chk("ce4_data", data, 0);
    if (tg.size() == 34) begin
      chk("ce4_pilot_half", tg[1] - tg[0], 8);
      chk("ce4_fetch_at_pilot_end", rd_cyc, tg[7]);
      chk("ce4_first_bit_half", tg[8] - rd_cyc, 16);
      chk("ce4_zero_half", tg[9] - tg[8], 16);
      chk("ce4_one_half", tg[10] - tg[9], 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
